crypto1_keystream: RTL and testbench
====================================

# crypto1_keystream

Forward Crypto1 cipher engine. It loads a 48-bit key, clocks the LFSR one bit per cycle with optional uid/nonce injection, and returns keystream words. It is the generating end of the key-search pipeline. It produces the keystream bitstreams that the key-search cores consume, and serves as the in-fabric golden reference for their recovered keys. Its output is bit-exact with the crapto1 software model (`crypto1_bit`).

## Interface
Parameters: none.

Ports:
- CLK  in  1  system clock.
- RESETn  in  1  reset, asynchronous, active-low.
- KEY  in  48  key loaded on a LOAD command; KEY[i] maps to s[i].
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when VALID&READY at a rising edge.
- CMD_LOAD  in  1  1 = load KEY; 0 = shift command.
- CMD_ENC  in  1  shift mode: 1 = XOR keystream into feedback (encrypted input).
- CMD_WORD  in  32  input bits injected into feedback, LSB first.
- CMD_NBITS  in  5  shift length minus one; n means n+1 bits (1..32).
- OUT_VALID  out  1  keystream word available.
- OUT_READY  in  1  consumer accepts the word.
- OUT_WORD  out  32  keystream, bit i = i-th shifted bit; bits above n are 0.
- STATE  out  48  current LFSR state (debug and bench).

## Operation
- LFSR convention: s[i] = s_{k+i}. Each shift computes ks and nxt from the current s, then sets s <= {nxt, s[47:1]}.
- Feedback: fb = ^(s & 48'h0E882B0AD621), taps 0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43.
  - nxt = fb ^ in_bit ^ (CMD_ENC ? ks : 0).
- Filter: x[j] = s[47-2j] for j = 0..19. Nibble m_k = x[4k+3:4k].
  - t0=0xF22C[m0], t1=0xD938[m1], t2=0xF22C[m2], t3=0xF22C[m3], t4=0xD938[m4].
  - ks = 0xEC57E80A[{t0,t1,t2,t3,t4}], with t0 as the MSB of the index.
- FSM states: IDLE, SHIFT, OUTPUT.
  - IDLE: CMD_READY=1.
    - On accept with LOAD=1: s<=KEY; stay in IDLE. No output word is produced.
    - On accept with LOAD=0: latch WORD, ENC, and cnt<=NBITS; clear the output shift register; go to SHIFT.
  - SHIFT: one bit per cycle, in_bit = word[idx] and ks into OUT_WORD[idx]. When idx==cnt, go to OUTPUT.
  - OUTPUT: OUT_VALID=1 and OUT_WORD held stable. When OUT_READY=1 at an edge, go to IDLE.
- CMD_READY=0 in SHIFT and OUTPUT. Commands arriving then are not accepted and must be held by the master.
- ks uses the pre-shift state; in encrypted mode it feeds nxt in the same cycle (crapto1 semantics).

## Timing
- Reset (async assert, sync release): state IDLE, s=0, STATE=0, OUT_VALID=0, OUT_WORD=0, CMD_READY=1 from the first cycle after release.
- LOAD: takes effect at the accepting edge; STATE shows KEY the next cycle. Back-to-back commands are allowed every cycle.
- Shift with length n+1: OUT_VALID rises n+1 edges after the accepting edge, so 32 edges for n=31 and 1 edge for n=0.
- OUT_VALID stays high with OUT_WORD unchanged until the OUT_READY handshake. It drops the cycle after; CMD_READY rises in the same cycle.
- Back-to-back throughput: n+3 cycles per shift command when OUT_READY is held high.
- Reset mid-SHIFT or mid-OUTPUT: all state is discarded immediately with no partial word, and the block returns to reset values.
- An all-zero state with zero input stays zero: ks=0 and fb=0.

## Structure
- crypto1_pkg holds:
  - the state_t enum (IDLE/SHIFT/OUTPUT);
  - the constants LFSR_TAPS=48'h0E882B0AD621, FA=16'hF22C, FB=16'hD938, FC=32'hEC57E80A;
  - the function extracting x[19:0] from s.
- Sub-module crypto1_filter: combinational, s[47:0] in and ks out. It is reused by the key-search side for candidate verification.
- Top level: FSM, 48-bit LFSR, 5-bit index counter, 32-bit input and output shift registers.

## Test plan
- Reset: hold RESETn=0 mid-SHIFT -> OUT_VALID=0, STATE=0, CMD_READY=1 immediately; after release the block accepts a LOAD at once.
- Zero key: LOAD 0, shift n=31, WORD=0, ENC=0 -> OUT_VALID 32 edges after accept, OUT_WORD=0, STATE=0.
- Known key: LOAD 48'hA0A1A2A3A4A5, shift n=31 then n=15 -> 48 keystream bits and STATE match the crapto1 model; OUT_WORD[31:16]=0 on the second word.
- Injection: LOAD key, shift WORD=32'hDEADBEEF with ENC=0, then the same WORD with ENC=1 -> both words and the final STATE match the model.
- Backpressure: hold OUT_READY=0 for 10 cycles -> OUT_WORD stable, CMD_READY=0, second CMD_VALID not accepted; release -> IDLE the next cycle.
- Minimum length: n=0 for 48 consecutive commands versus one n=31 plus one n=15 from the same key -> identical concatenated keystream.

Source files
------------

// File: rtl/crypto1_pkg.sv
// crypto1_pkg: shared definitions for the Crypto1 keystream engine and the
// key-search cores that reuse its filter.
//   state_t         : control FSM states of the keystream engine
//   LFSR_TAPS       : feedback tap mask over s[47:0]
//   FA, FB, FC      : nonlinear filter lookup tables
//   filter_inputs() : gathers the 20 filter input bits x[19:0] from s[47:0]
package crypto1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam logic [47:0] LFSR_TAPS = 48'h0E882B0AD621;
    localparam logic [15:0] FA        = 16'hF22C;
    localparam logic [15:0] FB        = 16'hD938;
    localparam logic [31:0] FC        = 32'hEC57E80A;

    // x[j] = s[47-2j]: the filter only looks at every other bit, counted
    // from the top of the register.
    function automatic logic [19:0] filter_inputs(input logic [47:0] s);
        logic [19:0] x;
        for (int j = 0; j < 20; j++) begin
            x[j] = s[47-2*j];
        end
        return x;
    endfunction

endpackage

// File: rtl/crypto1_filter.sv
// crypto1_filter: combinational Crypto1 output filter.
//   s_i  [47:0] : LFSR state
//   ks_o        : keystream bit for that state
// Five 4-input first-layer lookups feed one 5-input second-layer lookup;
// t0 (lowest nibble of x) forms the MSB of the second-layer index.
module crypto1_filter
    import crypto1_pkg::*;
(
    input  logic [47:0] s_i,
    output logic        ks_o
);

    logic [19:0] x;
    logic [4:0]  tidx;

    always_comb begin
        x       = filter_inputs(s_i);
        tidx[4] = FA[x[3:0]];
        tidx[3] = FB[x[7:4]];
        tidx[2] = FA[x[11:8]];
        tidx[1] = FA[x[15:12]];
        tidx[0] = FB[x[19:16]];
        ks_o    = FC[tidx];
    end

endmodule

// File: rtl/crypto1_keystream.sv
// crypto1_keystream: forward Crypto1 engine producing keystream words.
//   CLK, RESETn        : clock, asynchronous active-low reset
//   KEY       [47:0]   : key loaded by a LOAD command (KEY[i] -> s[i])
//   CMD_VALID/READY    : command handshake (accepted only in IDLE)
//   CMD_LOAD           : 1 = load KEY, 0 = shift CMD_NBITS+1 bits
//   CMD_ENC            : XOR keystream into feedback while shifting
//   CMD_WORD  [31:0]   : bits injected into feedback, LSB first
//   CMD_NBITS [4:0]    : shift length minus one
//   OUT_VALID/READY    : keystream word handshake
//   OUT_WORD  [31:0]   : keystream bits, bit i = i-th shifted bit
//   STATE     [47:0]   : current LFSR state
module crypto1_keystream
    import crypto1_pkg::*;
(
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [47:0] KEY,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_LOAD,
    input  logic        CMD_ENC,
    input  logic [31:0] CMD_WORD,
    input  logic [4:0]  CMD_NBITS,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_WORD,
    output logic [47:0] STATE
);

    state_t      state_q, state_d;
    logic [47:0] s_q, s_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        enc_q, enc_d;
    logic [31:0] win_q, win_d;
    logic [31:0] wout_q, wout_d;

    logic        ks;
    logic        fb;
    logic        nxt;

    crypto1_filter u_filter (
        .s_i  (s_q),
        .ks_o (ks)
    );

    // Keystream comes from the pre-shift state and, in encrypted mode,
    // feeds back into the same shift.
    always_comb begin
        fb  = ^(s_q & LFSR_TAPS);
        nxt = fb ^ win_q[idx_q] ^ (enc_q & ks);
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        win_d   = win_q;
        wout_d  = wout_q;
        unique case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    if (CMD_LOAD) begin
                        s_d = KEY;
                    end else begin
                        win_d   = CMD_WORD;
                        enc_d   = CMD_ENC;
                        cnt_d   = CMD_NBITS;
                        idx_d   = 5'd0;
                        wout_d  = 32'd0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                s_d           = {nxt, s_q[47:1]};
                wout_d[idx_q] = ks;
                if (idx_q == cnt_q) begin
                    state_d = OUTPUT;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            OUTPUT: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            s_q     <= 48'd0;
            idx_q   <= 5'd0;
            cnt_q   <= 5'd0;
            enc_q   <= 1'b0;
            win_q   <= 32'd0;
            wout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            enc_q   <= enc_d;
            win_q   <= win_d;
            wout_q  <= wout_d;
        end
    end

    assign CMD_READY = (state_q == IDLE);
    assign OUT_VALID = (state_q == OUTPUT);
    assign OUT_WORD  = wout_q;
    assign STATE     = s_q;

endmodule

// File: tb/tb_crypto1_keystream.sv
// Bench for crypto1_keystream: commands are driven from the main process,
// expected words come from a bit-serial reference model and are queued;
// a monitor pops and compares whenever the DUT presents a word.
module tb_crypto1_keystream;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [47:0] KEY;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_LOAD;
    logic        CMD_ENC;
    logic [31:0] CMD_WORD;
    logic [4:0]  CMD_NBITS;
    logic        OUT_VALID;
    wire         OUT_READY;
    logic [31:0] OUT_WORD;
    logic [47:0] STATE;

    crypto1_keystream dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .KEY       (KEY),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_LOAD  (CMD_LOAD),
        .CMD_ENC   (CMD_ENC),
        .CMD_WORD  (CMD_WORD),
        .CMD_NBITS (CMD_NBITS),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_WORD  (OUT_WORD),
        .STATE     (STATE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc++;

    // Output backpressure: either forced low, random, or always ready.
    logic force_low = 1'b0;
    logic rand_rdy  = 1'b0;
    logic rnd       = 1'b1;
    assign OUT_READY = !force_low && rnd;
    always @(posedge CLK) begin
        #2;
        rnd = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int taps[18] = '{0, 5, 9, 10, 12, 14, 15, 17, 19, 24, 25, 27, 29, 35, 39, 41, 42, 43};
    int ftbl[5]  = '{32'hF22C, 32'hD938, 32'hF22C, 32'hF22C, 32'hD938};
    logic [31:0] fc_tbl = 32'hEC57E80A;

    function automatic bit mparity(input logic [47:0] s);
        bit p = 1'b0;
        for (int i = 0; i < 18; i++) p ^= s[taps[i]];
        return p;
    endfunction

    function automatic bit mfilt(input logic [47:0] s);
        int idx = 0;
        for (int k = 0; k < 5; k++) begin
            int m = 0;
            for (int b = 0; b < 4; b++) begin
                if (s[47 - 2*(4*k + b)]) m += (1 << b);
            end
            idx = idx * 2 + ((ftbl[k] >> m) & 1);
        end
        return fc_tbl[idx];
    endfunction

    task automatic model_run(inout logic [47:0] s, input logic [31:0] w, input int n,
                             input bit enc, output logic [31:0] ks_w);
        ks_w = 32'd0;
        for (int i = 0; i <= n; i++) begin
            bit k  = mfilt(s);
            bit nx = mparity(s) ^ w[i] ^ (enc & k);
            ks_w[i] = k;
            s = (s >> 1) | ({47'd0, nx} << 47);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] word;
        logic [47:0] st;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    logic [31:0] got_q[$];
    logic [47:0] model_s = 48'd0;
    bit          seen = 1'b0;

    always @(negedge CLK) begin
        if (!RESETn) begin
            seen = 1'b0;
        end else if (OUT_VALID) begin
            if (!seen) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=%h exp=none", OUT_WORD);
                    cur.word = OUT_WORD;
                    cur.st   = STATE;
                end else begin
                    cur = sbq.pop_front();
                    check("out_latency", 64'(cyc), 64'(cur.due));
                    got_q.push_back(OUT_WORD);
                end
                seen = 1'b1;
            end
            check("out_word", {32'd0, OUT_WORD}, {32'd0, cur.word});
            check("out_state", {16'd0, STATE}, {16'd0, cur.st});
            check("cmd_ready_in_output", {63'd0, CMD_READY}, 64'd0);
        end else begin
            seen = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit load, input bit enc, input logic [31:0] word,
                        input logic [4:0] n, input logic [47:0] key, output int waited);
        exp_t e;
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_LOAD  = load;
        CMD_ENC   = enc;
        CMD_WORD  = word;
        CMD_NBITS = n;
        KEY       = key;
        waited    = 0;
        while (!CMD_READY) begin
            @(negedge CLK);
            waited++;
            if (waited > 1000) begin
                checks++;
                errors++;
                $display("FAIL cmd_accept_timeout got=waiting exp=accepted");
                CMD_VALID = 1'b0;
                return;
            end
        end
        if (load) begin
            model_s = key;
        end else begin
            e.due = cyc + int'(n) + 2;
            model_run(model_s, word, int'(n), enc, e.word);
            e.st = model_s;
            sbq.push_back(e);
        end
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge CLK);
        while (sbq.size() != 0 || !CMD_READY) begin
            @(negedge CLK);
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout got=busy exp=idle");
                return;
            end
        end
    endtask

    initial begin
        int          w;
        logic [47:0] k;
        logic [47:0] ms;
        logic [31:0] kw0, kw1;
        logic [47:0] exp48, dut48;

        RESETn    = 1'b0;
        CMD_VALID = 1'b0;
        CMD_LOAD  = 1'b0;
        CMD_ENC   = 1'b0;
        CMD_WORD  = 32'd0;
        CMD_NBITS = 5'd0;
        KEY       = 48'd0;
        repeat (3) @(negedge CLK);
        check("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        check("rst_state", {16'd0, STATE}, 64'd0);
        check("rst_out_word", {32'd0, OUT_WORD}, 64'd0);
        RESETn = 1'b1;
        @(negedge CLK);
        check("rst_cmd_ready", {63'd0, CMD_READY}, 64'd1);

        // Zero key stays zero
        send(1, 0, 32'd0, 5'd0, 48'd0, w);
        send(0, 0, 32'd0, 5'd31, 48'd0, w);
        wait_idle();
        check("zero_state", {16'd0, STATE}, 64'd0);

        // Known key, 32 + 16 bits
        got_q.delete();
        send(1, 0, 32'd0, 5'd0, 48'hA0A1A2A3A4A5, w);
        @(negedge CLK);
        check("load_state", {16'd0, STATE}, {16'd0, 48'hA0A1A2A3A4A5});
        send(0, 0, 32'd0, 5'd31, 48'd0, w);
        send(0, 0, 32'd0, 5'd15, 48'd0, w);
        wait_idle();
        check("known_nwords", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            kw1 = got_q[1];
            check("known_upper_zero", {48'd0, kw1[31:16]}, 64'd0);
        end

        // Injection plain then encrypted
        send(1, 0, 32'd0, 5'd0, 48'h123456789ABC, w);
        send(0, 0, 32'hDEADBEEF, 5'd31, 48'd0, w);
        send(0, 1, 32'hDEADBEEF, 5'd31, 48'd0, w);
        wait_idle();
        check("inject_state", {16'd0, STATE}, {16'd0, model_s});

        // Backpressure
        send(1, 0, 32'd0, 5'd0, 48'h5A5A00FFC3C3, w);
        force_low = 1'b1;
        send(0, 1, 32'hCAFEF00D, 5'd3, 48'd0, w);
        w = 0;
        while (!OUT_VALID && w < 100) begin
            @(negedge CLK);
            w++;
        end
        CMD_VALID = 1'b1;
        CMD_LOAD  = 1'b1;
        KEY       = 48'hFFFF0000FFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("bp_out_valid", {63'd0, OUT_VALID}, 64'd1);
            check("bp_cmd_ready", {63'd0, CMD_READY}, 64'd0);
            check("bp_state_held", {16'd0, STATE}, {16'd0, model_s});
        end
        force_low = 1'b0;
        @(negedge CLK);
        check("bp_released_valid", {63'd0, OUT_VALID}, 64'd0);
        check("bp_released_ready", {63'd0, CMD_READY}, 64'd1);
        model_s = 48'hFFFF0000FFFF;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        @(negedge CLK);
        check("bp_late_load", {16'd0, STATE}, {16'd0, 48'hFFFF0000FFFF});

        // Minimum length: 48 single-bit shifts vs 32 + 16
        k  = 48'h3C5A96E10F7B;
        ms = k;
        model_run(ms, 32'd0, 31, 1'b0, kw0);
        model_run(ms, 32'd0, 15, 1'b0, kw1);
        exp48 = {kw1[15:0], kw0};
        send(1, 0, 32'd0, 5'd0, k, w);
        got_q.delete();
        for (int i = 0; i < 48; i++) send(0, 0, 32'd0, 5'd0, 48'd0, w);
        wait_idle();
        dut48 = 48'd0;
        check("min_nwords", 64'(got_q.size()), 64'd48);
        for (int i = 0; i < 48 && i < got_q.size(); i++) dut48[i] = got_q[i][0];
        check("min_concat", {16'd0, dut48}, {16'd0, exp48});
        send(1, 0, 32'd0, 5'd0, k, w);
        got_q.delete();
        send(0, 0, 32'd0, 5'd31, 48'd0, w);
        send(0, 0, 32'd0, 5'd15, 48'd0, w);
        wait_idle();
        dut48 = 48'd0;
        if (got_q.size() == 2) dut48 = {got_q[1][15:0], got_q[0]};
        check("long_concat", {16'd0, dut48}, {16'd0, exp48});

        // Randomized commands with random output backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0)
                send(1, 0, 32'd0, 5'd0, {16'($urandom), 32'($urandom)}, w);
            else
                send(0, 1'($urandom_range(0, 1)), 32'($urandom), 5'($urandom_range(0, 31)), 48'd0, w);
        end
        wait_idle();
        rand_rdy = 1'b0;
        check("rand_state", {16'd0, STATE}, {16'd0, model_s});

        // Reset in the middle of a shift
        send(1, 0, 32'd0, 5'd0, 48'h0123456789AB, w);
        send(0, 0, 32'h55AA55AA, 5'd31, 48'd0, w);
        repeat (5) @(negedge CLK);
        #2 RESETn = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        check("midrst_state", {16'd0, STATE}, 64'd0);
        check("midrst_cmd_ready", {63'd0, CMD_READY}, 64'd1);
        check("midrst_out_word", {32'd0, OUT_WORD}, 64'd0);
        sbq.delete();
        model_s = 48'd0;
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        send(1, 0, 32'd0, 5'd0, 48'hBEEF00C0FFEE, w);
        check("post_rst_accept_wait", 64'(w), 64'd0);
        @(negedge CLK);
        check("post_rst_load", {16'd0, STATE}, {16'd0, 48'hBEEF00C0FFEE});
        send(0, 0, 32'd0, 5'd7, 48'd0, w);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
